// File: rtl/sp_ram_param.sv
// -----------------------------------------------------------------------------
// sp_ram_param
//   Single-port synchronous RAM. It has byte write enables, a selectable write
//   mode (normal / write-through / read-before-write), an optional output
//   pipeline register, and an optional clear sequencer. The clear sequencer
//   fills the array with INIT_VALUE after reset.
//
// Parameters
//   DATA_WIDTH     word width, multiple of 8 (8..64)
//   ADDR_WIDTH     address width; DEPTH = 2**ADDR_WIDTH
//   READ_MODE      0 = bypass (1-cycle latency), 1 = pipelined (2-cycle, oce)
//   WRITE_MODE     0 = normal, 1 = write-through, 2 = read-before-write
//   CLEAR_ON_RESET 1 = fill array with INIT_VALUE after reset
//   INIT_VALUE     fill word used by the clear sequencer
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   ce     in   access enable
//   oce    in   output register enable (READ_MODE=1 only)
//   wre    in   1 = write, 0 = read (qualified by ce)
//   be     in   byte write enables, be[i] -> din[8i+7:8i]
//   ad     in   word address
//   din    in   write data
//   dout   out  read data
//   busy   out  clear sequencer active; user accesses are ignored
// -----------------------------------------------------------------------------
module sp_ram_param #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           READ_MODE      = 0,
  parameter int unsigned           WRITE_MODE     = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    oce,
  input  logic                    wre,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   ad,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  // Shared write port. It is driven either by the clear sequencer or by the user.
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     wr_be;

  // Array-output stage
  logic [DATA_WIDTH-1:0] ram_q, ram_d;

  // Read word and the word that results after merging the current write into it
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign busy = (state_q == CLEAR);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and write-port steering
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_addr   = ad;
    wr_data   = din;
    wr_be     = '0;

    unique case (state_q)
      CLEAR: begin
        // The clear sequencer owns the port and writes whole words.
        // The counter wraps to 0 on the last word, so a later clear
        // starts from address 0 again.
        wr_addr   = clr_cnt_q;
        wr_data   = INIT_VALUE;
        wr_be     = '1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        if (ce && wre) begin
          wr_be = be;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write (byte-lane enables; no reset so it maps to block RAM)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array-output stage
  // ---------------------------------------------------------------------------
  assign rd_word = mem[ad];

  always_comb begin
    merged_word = rd_word;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  always_comb begin
    ram_d = ram_q;
    if (state_q == CLEAR) begin
      ram_d = '0;
    end else if (ce) begin
      if (!wre) begin
        ram_d = rd_word;
      end else if (WRITE_MODE == 1) begin
        ram_d = merged_word;
      end else if (WRITE_MODE == 2) begin
        // The nonblocking array update makes rd_word the pre-write contents.
        ram_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q <= '0;
    end else begin
      ram_q <= ram_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read output: either direct from the array stage, or via an oce-gated
  // register
  // ---------------------------------------------------------------------------
  if (READ_MODE == 1) begin : g_pipe
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (state_q == CLEAR) begin
        dout_d = '0;
      end else if (oce) begin
        dout_d = ram_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end else begin : g_bypass
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = ram_q;
  end

endmodule

// File: tb/tb_sp_ram_param.sv
module tb_sp_ram_param;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        ce    = 1'b0;
  logic        oce   = 1'b1;
  logic        wre   = 1'b0;
  logic [1:0]  be    = '0;
  logic [3:0]  ad    = '0;
  logic [15:0] din   = '0;

  logic [15:0] dout0, dout1, dout2, dout3, dout4;
  logic        busy0, busy1, busy2, busy3, busy4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // u0: bypass, normal write
  sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(0), .WRITE_MODE(0),
                 .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
    .ad(ad), .din(din), .dout(dout0), .busy(busy0));

  // u1: write-through
  sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(0), .WRITE_MODE(1),
                 .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
    .ad(ad), .din(din), .dout(dout1), .busy(busy1));

  // u2: read-before-write
  sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(0), .WRITE_MODE(2),
                 .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
    .ad(ad), .din(din), .dout(dout2), .busy(busy2));

  // u3: pipelined read
  sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(1), .WRITE_MODE(0),
                 .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
    .ad(ad), .din(din), .dout(dout3), .busy(busy3));

  // u4: no clear on reset
  sp_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(0), .WRITE_MODE(0),
                 .CLEAR_ON_RESET(0), .INIT_VALUE(16'hA5A5)) u4 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be),
    .ad(ad), .din(din), .dout(dout4), .busy(busy4));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic w, input logic [3:0] a, input logic [15:0] d,
                     input logic [1:0] b);
    ce  = 1'b1;
    wre = w;
    ad  = a;
    din = d;
    be  = b;
    tick();
  endtask

  task automatic idle();
    ce  = 1'b0;
    wre = 1'b0;
    be  = '0;
    tick();
  endtask

  // Count busy cycles (bounded), checking that dout stays 0 throughout.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      chk({tag, "_dout0"}, dout0, 16'h0000);
      chk({tag, "_dout3"}, dout3, 16'h0000);
      tick();
      n++;
    end
    chk({tag, "_busy_cycles"}, 16'(n), 16'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy0", 16'(busy0), 16'd1);
    chk("rst_busy4", 16'(busy4), 16'd0);
    chk("rst_dout0", dout0, 16'h0000);
    chk("rst_dout3", dout3, 16'h0000);
    chk("rst_dout4", dout4, 16'h0000);

    // Release reset with a write to addr 2 held during the whole clear
    ce = 1'b1; wre = 1'b1; ad = 4'd2; din = 16'hFFFF; be = 2'b11;
    reset = 1'b0;
    wait_clear("clr1");
    chk("post_clr_busy0", 16'(busy0), 16'd0);
    chk("post_clr_busy4", 16'(busy4), 16'd0);

    // Every word is cleared, and the lockout write to addr 2 was ignored.
    // u4 has no sequencer, so it accepted the write.
    for (int a = 0; a < 16; a++) begin
      acc(1'b0, 4'(a), 16'h0000, 2'b00);
      chk("clr_read", dout0, 16'hA5A5);
      if (a == 2) chk("noclr_write_addr2", dout4, 16'hFFFF);
    end

    // Byte enables
    acc(1'b1, 4'd3, 16'h1234, 2'b11);
    acc(1'b1, 4'd3, 16'hABCD, 2'b01);
    acc(1'b0, 4'd3, 16'h0000, 2'b00);
    chk("be_merge", dout0, 16'h12CD);
    chk("be_merge_u4", dout4, 16'h12CD);

    // Write modes
    acc(1'b1, 4'd5, 16'h1111, 2'b11);
    acc(1'b0, 4'd0, 16'h0000, 2'b00);
    chk("wm_pre_read", dout0, 16'hA5A5);
    acc(1'b1, 4'd5, 16'h2222, 2'b11);
    chk("wm0_hold", dout0, 16'hA5A5);
    chk("wm1_through", dout1, 16'h2222);
    chk("wm2_rbw", dout2, 16'h1111);
    acc(1'b1, 4'd5, 16'h0000, 2'b00);
    chk("wm0_be0_hold", dout0, 16'hA5A5);
    chk("wm1_be0", dout1, 16'h2222);
    chk("wm2_be0", dout2, 16'h2222);
    acc(1'b0, 4'd5, 16'h0000, 2'b00);
    chk("wm_readback", dout0, 16'h2222);

    // Pipelined read
    acc(1'b1, 4'd7, 16'h7777, 2'b11);
    oce = 1'b1;
    acc(1'b0, 4'd0, 16'h0000, 2'b00);
    idle();
    chk("pipe_pre", dout3, 16'hA5A5);
    acc(1'b0, 4'd7, 16'h0000, 2'b00);
    chk("pipe_one_edge", dout3, 16'hA5A5);
    idle();
    chk("pipe_two_edges", dout3, 16'h7777);
    acc(1'b0, 4'd0, 16'h0000, 2'b00);
    oce = 1'b0;
    idle();
    chk("pipe_oce0_hold", dout3, 16'h7777);
    oce = 1'b1;
    idle();
    chk("pipe_oce1_load", dout3, 16'hA5A5);

    // Reset during the clear
    reset = 1'b1;
    #1;
    chk("async_rst_dout0", dout0, 16'h0000);
    chk("async_rst_dout3", dout3, 16'h0000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mid_busy", 16'(busy0), 16'd1);
      chk("mid_dout", dout0, 16'h0000);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 16'(busy0), 16'd1);
    chk("mid_rst_dout", dout0, 16'h0000);
    chk("mid_rst_busy4", 16'(busy4), 16'd0);
    tick();
    reset = 1'b0;
    wait_clear("clr2");
    acc(1'b0, 4'd3, 16'h0000, 2'b00);
    chk("reclear_addr3", dout0, 16'hA5A5);
    chk("noclr_keeps_addr3", dout4, 16'h12CD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram_param.md
SP_RAM_PARAM -- requirements
Module: sp_ram_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_MODE, default 0: 0 = bypass (1-cycle read latency), 1 = pipeline (2-cycle read latency, output register gated by oce).
REQ-004 SHALL have parameter WRITE_MODE, default 0: 0 = normal, 1 = write-through, 2 = read-before-write.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = memory is cleared to INIT_VALUE after reset, 0 = no clear.
REQ-006 SHALL have parameter INIT_VALUE, default 0: DATA_WIDTH-bit fill word used by the clear sequencer.
REQ-007 SHALL have the following ports, one per line:
- clk  input  1  sole clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- ce  input  1  access enable.
- oce  input  1  output-register enable; used only when READ_MODE=1.
- wre  input  1  1 = write, 0 = read, qualified by ce.
- be  input  DATA_WIDTH/8  byte write enables; be[i] covers din[8i+7:8i].
- ad  input  ADDR_WIDTH  word address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data.
- busy  output  1  clear sequencer active; user access is ignored.

Function
REQ-008 SHALL hold a DEPTH x DATA_WIDTH array inferable as block RAM; no asynchronous read path.
REQ-009 SHALL implement a state machine with states CLEAR and READY, plus a clear counter of width ADDR_WIDTH.
REQ-010 In CLEAR, SHALL write INIT_VALUE to word clr_cnt on each cycle, with all bytes written, and increment clr_cnt from 0.
REQ-011 SHALL go from CLEAR to READY on the edge that writes word DEPTH-1; busy SHALL be 1 for exactly DEPTH cycles after reset deasserts.
REQ-012 While busy=1, SHALL ignore ce, wre, be, ad and din, and SHALL hold dout at 0.
REQ-013 In READY with ce=1 and wre=1, SHALL write each byte lane i with be[i]=1 at the edge; lanes with be[i]=0 SHALL keep their contents.
REQ-014 When ce=1 and wre=0, the array-output stage SHALL load mem[ad] at the edge.
REQ-015 When ce=1 and wre=1, the array-output stage SHALL update by mode:
- WRITE_MODE 0: hold.
- WRITE_MODE 1: load the post-write merged word.
- WRITE_MODE 2: load the pre-write word.
REQ-016 When ce=0, SHALL hold the array-output stage and leave memory unchanged.
REQ-017 With READ_MODE=0, dout SHALL equal the array-output stage, giving read data one edge after the request.
REQ-018 With READ_MODE=1, dout SHALL load the array-output stage on edges with oce=1 and hold when oce=0, giving read data two edges after the request when oce=1.
REQ-019 Back-to-back accesses on consecutive cycles SHALL be fully supported at full throughput with no stall.
REQ-020 Address wrap needs no special handling; every ad value maps to a distinct word.
REQ-021 A write with be all zero SHALL leave memory unchanged; the output stage still follows REQ-015, and under WRITE_MODE 1 it loads the unchanged word.

Reset
REQ-022 While reset=1, dout SHALL be 0, both output stages SHALL be 0, and clr_cnt SHALL be 0.
REQ-023 While reset=1, state SHALL be CLEAR with busy=1 if CLEAR_ON_RESET=1, otherwise READY with busy=0.
REQ-024 Reset asserted mid-clear SHALL restart the clear from address 0 after deassertion.
REQ-025 With CLEAR_ON_RESET=0, memory contents SHALL be undefined after reset and SHALL NOT be altered by reset.

Verification
REQ-026 Bench SHALL use DATA_WIDTH=16 and ADDR_WIDTH=4 unless stated otherwise, and SHALL cover:
- Clear: INIT_VALUE=0xA5A5, release reset -> busy=1 for 16 cycles, then 0; reads of addresses 0..15 return 0xA5A5.
- Byte enables: write 0x1234 be=11 at addr 3, then 0xABCD be=01 -> read addr 3 returns 0x12CD.
- Write modes on addr 5 holding 0x1111, write 0x2222 be=11, compare dout after the write edge:
  - WRITE_MODE 0: previous dout.
  - WRITE_MODE 1: 0x2222.
  - WRITE_MODE 2: 0x1111.
- Pipeline: READ_MODE=1, read addr 7 holding 0x7777 -> dout=0x7777 two edges later with oce=1; with oce=0 on the second edge, dout holds its old value.
- Busy lockout: write 0xFFFF to addr 2 during the clear -> after the clear, addr 2 reads INIT_VALUE.
- Mid-clear reset: assert reset at clear cycle 6 for 2 cycles -> busy again 16 cycles after release; dout=0 throughout.
